// File: rtl/sched_pkg.sv
// Shared types and the single-step arithmetic for the round-robin job scheduler.
package sched_pkg;

  localparam int CNT_W  = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_XOR,
    OP_PASS
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [CNT_W-1:0] cnt;
    int               operand;
  } job_t;

  // One accumulate step. The arithmetic is 32-bit modular, so overflow wraps.
  function automatic logic [DATA_W-1:0] apply_op(
    input op_e               op,
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] operand
  );
    logic [DATA_W-1:0] result;
    unique case (op)
      OP_ADD:  result = acc + operand;
      OP_SUB:  result = acc - operand;
      OP_XOR:  result = acc ^ operand;
      OP_PASS: result = operand;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr and wraps
// modulo NUM_REQ. The first asserted request wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] slot;

  // Walk the requesters in priority order starting at ptr and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop, so the block cannot infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    slot  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(off);
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      slot = sum[ID_W-1:0];
      if (!any && req[slot]) begin
        grant[slot] = 1'b1;
        idx         = slot;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/job_rr_scheduler.sv
// Round-robin scheduler that shares one iterative 32-bit accumulate datapath
// among NUM_REQ requesters. The scheduler grants a job in IDLE, steps it once
// per RUNNING cycle and holds the result in DONE until the consumer takes it.
module job_rr_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = sched_pkg::CNT_W,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  job_t [NUM_REQ-1:0]   req_job,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic [DATA_W-1:0]    res_data,
  output state_e               state
);

  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               accept;
  job_t               sel_job;
  logic [CNT_W-1:0]   remaining;
  logic [DATA_W-1:0]  acc;
  logic [DATA_W-1:0]  acc_next;
  op_e                job_op;
  logic [DATA_W-1:0]  job_operand;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Offer the grant only in IDLE and outside reset, so req_ready stays low while rst_n is held.
  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign accept    = grant_any && (state == IDLE) && rst_n;
  assign sel_job   = req_job[grant_idx];
  assign acc_next  = apply_op(job_op, acc, job_operand);

  // Scheduler FSM with the job counter, the accumulator and the registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: reset clears every control and data register so that an aborted job leaves no trace.
      state       <= IDLE;
      rr_ptr      <= '0;
      remaining   <= '0;
      acc         <= '0;
      job_op      <= OP_ADD;
      job_operand <= '0;
      res_valid   <= 1'b0;
      res_id      <= '0;
      res_data    <= '0;
    end else begin
      // NOTE: the block uses non-blocking assignments, so every branch reads the state from before the edge.
      unique case (state)
        IDLE: begin
          if (accept) begin
            job_op      <= sel_job.op;
            job_operand <= sel_job.operand;
            acc         <= '0;
            res_id      <= grant_idx;
            rr_ptr      <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            if (sel_job.cnt == '0) begin
              res_data  <= '0;
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              remaining <= sel_job.cnt;
              state     <= RUNNING;
            end
          end
        end
        RUNNING: begin
          acc       <= acc_next;
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            res_data  <= acc_next;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
